// File: rtl/core_inst_pkg.sv
// Shared definitions for the core instruction sequencer: FSM states, inst bus
// field positions, the NOP word and the word packing function.
package core_inst_pkg;

    localparam int INST_W   = 35;
    localparam int FIELD_AW = 11;

    localparam int MODE_BIT      = 34;
    localparam int ACC_BIT       = 33;
    localparam int PSUM_CEN_BIT  = 32;
    localparam int PSUM_WEN_BIT  = 31;
    localparam int PSUM_ADDR_LSB = 20;
    localparam int XMEM_CEN_BIT  = 19;
    localparam int XMEM_WEN_BIT  = 18;
    localparam int XMEM_ADDR_LSB = 7;
    localparam int OFIFO_RD_BIT  = 6;
    localparam int IFIFO_WR_BIT  = 5;
    localparam int IFIFO_RD_BIT  = 4;
    localparam int L0_RD_BIT     = 3;
    localparam int L0_WR_BIT     = 2;
    localparam int EXECUTE_BIT   = 1;
    localparam int LOAD_BIT      = 0;

    // Both SRAMs deselected (CEN/WEN are active-low), every strobe low.
    localparam logic [INST_W-1:0] INST_NOP = 35'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_KRD, S_KLD, S_KDRN, S_ARD, S_EXE, S_ORD, S_ACC, S_DONE
    } state_t;

    typedef struct packed {
        logic                mode;
        logic                acc;
        logic                psum_cen;
        logic                psum_wen;
        logic [FIELD_AW-1:0] psum_addr;
        logic                xmem_cen;
        logic                xmem_wen;
        logic [FIELD_AW-1:0] xmem_addr;
        logic                ofifo_rd;
        logic                ififo_wr;
        logic                ififo_rd;
        logic                l0_rd;
        logic                l0_wr;
        logic                execute;
        logic                load;
    } fields_t;

    function automatic logic [INST_W-1:0] build_inst(input fields_t f);
        logic [INST_W-1:0] w;
        w = '0;
        w[MODE_BIT]                           = f.mode;
        w[ACC_BIT]                            = f.acc;
        w[PSUM_CEN_BIT]                       = f.psum_cen;
        w[PSUM_WEN_BIT]                       = f.psum_wen;
        w[PSUM_ADDR_LSB +: FIELD_AW]          = f.psum_addr;
        w[XMEM_CEN_BIT]                       = f.xmem_cen;
        w[XMEM_WEN_BIT]                       = f.xmem_wen;
        w[XMEM_ADDR_LSB +: FIELD_AW]          = f.xmem_addr;
        w[OFIFO_RD_BIT]                       = f.ofifo_rd;
        w[IFIFO_WR_BIT]                       = f.ififo_wr;
        w[IFIFO_RD_BIT]                       = f.ififo_rd;
        w[L0_RD_BIT]                          = f.l0_rd;
        w[L0_WR_BIT]                          = f.l0_wr;
        w[EXECUTE_BIT]                        = f.execute;
        w[LOAD_BIT]                           = f.load;
        return w;
    endfunction

endpackage

// File: rtl/core_inst_pkt.sv
// Registered packer: turns the sequencer's decoded fields into the inst word
// and aligns the done pulse with the word issued in the DONE state.
module core_inst_pkt
    import core_inst_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  fields_t           fields,
    input  logic              done_in,
    output logic [INST_W-1:0] inst,
    output logic              done
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst <= INST_NOP;
            done <= 1'b0;
        end else begin
            inst <= build_inst(fields);
            done <= done_in;
        end
    end

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer walking one convolution tile on the core inst bus.
// Optional CORE_INST_SEQ_PERF_EN adds cyc_cnt / stall_cnt performance counters.
module core_inst_seq
    import core_inst_pkg::*;
#(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int len_kij  = 9,
    parameter int len_nij  = 36,
    parameter int addr_bw  = 11,
    parameter int w_base   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              ofifo_valid,
    output logic              busy,
    output logic              done,
    output logic [INST_W-1:0] inst
`ifdef CORE_INST_SEQ_PERF_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [31:0] ROW_N     = row;
    localparam logic [31:0] COL_N     = col;
    localparam logic [31:0] KIJ_N     = len_kij;
    localparam logic [31:0] NIJ_N     = len_nij;
    localparam logic [31:0] ACC_N     = len_nij * len_kij;
    localparam logic [31:0] W_BASE_N  = w_base;
    localparam logic [31:0] ADDR_MASK = (32'd1 << addr_bw) - 32'd1;

    state_t      state;
    state_t      succ;
    logic [31:0] cnt;
    logic [31:0] kij;
    logic [31:0] acc_k;
    logic [31:0] acc_o;
    logic        mode_q;
    logic        last;
    fields_t     fields;

    function automatic logic [FIELD_AW-1:0] to_field(input logic [31:0] a);
        return FIELD_AW'(a & ADDR_MASK);
    endfunction

    assign busy = (state != S_IDLE);

    always_comb begin
        last = 1'b0;
        succ = S_IDLE;
        case (state)
            S_KRD:  begin last = (cnt == COL_N);                      succ = S_KLD;  end
            S_KLD:  begin last = (cnt == COL_N - 1);                  succ = S_KDRN; end
            S_KDRN: begin last = (cnt == ROW_N - 1);                  succ = S_ARD;  end
            S_ARD:  begin last = (cnt == NIJ_N);                      succ = S_EXE;  end
            S_EXE:  begin last = (cnt == NIJ_N - 1);                  succ = S_ORD;  end
            S_ORD:  begin
                last = ofifo_valid && (cnt == NIJ_N - 1);
                succ = (kij == KIJ_N - 1) ? S_ACC : S_KRD;
            end
            S_ACC:  begin last = (cnt == ACC_N);                      succ = S_DONE; end
            default: begin last = 1'b0;                               succ = S_IDLE; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            kij    <= '0;
            acc_k  <= '0;
            acc_o  <= '0;
            mode_q <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start) begin
                state  <= S_KRD;
                mode_q <= mode;
                cnt    <= '0;
                kij    <= '0;
            end
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end else if (last) begin
            state <= succ;
            cnt   <= '0;
            if (state == S_ORD) begin
                if (kij == KIJ_N - 1) begin
                    acc_k <= '0;
                    acc_o <= '0;
                end else begin
                    kij <= kij + 1;
                end
            end
        end else if (state != S_ORD || ofifo_valid) begin
            cnt <= cnt + 1;
            // Readout walks kij fastest so each output row is summed over all kernels.
            if (state == S_ACC) begin
                if (acc_k == KIJ_N - 1) begin
                    acc_k <= '0;
                    acc_o <= acc_o + 1;
                end else begin
                    acc_k <= acc_k + 1;
                end
            end
        end
    end

    always_comb begin
        fields          = '0;
        fields.psum_cen = 1'b1;
        fields.psum_wen = 1'b1;
        fields.xmem_cen = 1'b1;
        fields.xmem_wen = 1'b1;
        fields.mode     = (state != S_IDLE) ? mode_q : 1'b0;
        case (state)
            S_KRD: begin
                if (cnt < COL_N) begin
                    fields.xmem_cen  = 1'b0;
                    fields.xmem_addr = to_field(W_BASE_N + kij * COL_N + cnt);
                end
                // l0 write trails the read by the SRAM's one-cycle latency.
                fields.l0_wr = (cnt != 0);
            end
            S_KLD: begin
                fields.load  = 1'b1;
                fields.l0_rd = 1'b1;
            end
            S_ARD: begin
                if (cnt < NIJ_N) begin
                    fields.xmem_cen  = 1'b0;
                    fields.xmem_addr = to_field(cnt);
                end
                fields.l0_wr = (cnt != 0);
            end
            S_EXE: begin
                fields.execute = 1'b1;
                fields.l0_rd   = 1'b1;
            end
            S_ORD: begin
                if (ofifo_valid) begin
                    fields.ofifo_rd  = 1'b1;
                    fields.psum_cen  = 1'b0;
                    fields.psum_wen  = 1'b0;
                    fields.psum_addr = to_field(kij * NIJ_N + cnt);
                end
            end
            S_ACC: begin
                if (cnt < ACC_N) begin
                    fields.psum_cen  = 1'b0;
                    fields.psum_addr = to_field(acc_k * NIJ_N + acc_o);
                end
                fields.acc = (cnt != 0);
            end
            default: ;
        endcase
    end

    core_inst_pkt u_pkt (
        .clk     (clk),
        .reset   (reset),
        .fields  (fields),
        .done_in (state == S_DONE),
        .inst    (inst),
        .done    (done)
    );

`ifdef CORE_INST_SEQ_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                cyc_cnt   <= '0;
                stall_cnt <= '0;
            end
        end else begin
            cyc_cnt <= cyc_cnt + 1;
            if (state == S_ORD && !ofifo_valid) begin
                stall_cnt <= stall_cnt + 1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_inst_seq.sv
// Bench for core_inst_seq: three parameterisations exercising the full tile,
// short-tile timing, ORD stalls and ACC readout order.
module tb_core_inst_seq;

    localparam logic [34:0] NOP = 35'h1_800C_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic rst_a, start_a, mode_a, valid_a, busy_a, done_a;
    logic rst_b, start_b, mode_b, valid_b, busy_b, done_b;
    logic rst_c, start_c, mode_c, valid_c, busy_c, done_c;
    logic [34:0] inst_a, inst_b, inst_c;
`ifdef CORE_INST_SEQ_PERF_EN
    logic [31:0] cyc_a, stall_a, cyc_b, stall_b, cyc_c, stall_c;
`endif

    core_inst_seq #(.row(8), .col(8), .len_kij(9), .len_nij(36), .addr_bw(11), .w_base(1024)) u_a (
        .clk(clk), .reset(rst_a), .start(start_a), .mode(mode_a), .ofifo_valid(valid_a),
        .busy(busy_a), .done(done_a), .inst(inst_a)
`ifdef CORE_INST_SEQ_PERF_EN
        , .cyc_cnt(cyc_a), .stall_cnt(stall_a)
`endif
    );

    core_inst_seq #(.row(8), .col(8), .len_kij(1), .len_nij(4), .addr_bw(11), .w_base(1024)) u_b (
        .clk(clk), .reset(rst_b), .start(start_b), .mode(mode_b), .ofifo_valid(valid_b),
        .busy(busy_b), .done(done_b), .inst(inst_b)
`ifdef CORE_INST_SEQ_PERF_EN
        , .cyc_cnt(cyc_b), .stall_cnt(stall_b)
`endif
    );

    core_inst_seq #(.row(8), .col(8), .len_kij(3), .len_nij(2), .addr_bw(11), .w_base(1024)) u_c (
        .clk(clk), .reset(rst_c), .start(start_c), .mode(mode_c), .ofifo_valid(valid_c),
        .busy(busy_c), .done(done_c), .inst(inst_c)
`ifdef CORE_INST_SEQ_PERF_EN
        , .cyc_cnt(cyc_c), .stall_cnt(stall_c)
`endif
    );

    typedef struct packed {
        logic        valid_in;
        logic        exp_done;
        logic [34:0] exp_inst;
    } vec_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [34:0] inst;
    } obs_t;

    vec_t ord_tbl[6];
    vec_t acc_tbl[8];
    obs_t sb[$];

    int busy_cnt, done_cnt, exe_cnt;

    function automatic logic [34:0] mkw(input logic md, input logic acc, input logic pcen,
                                        input logic pwen, input logic [10:0] paddr,
                                        input logic xcen, input logic xwen, input logic [10:0] xaddr,
                                        input logic ofrd, input logic l0rd, input logic l0wr,
                                        input logic exe, input logic ld);
        logic [34:0] w;
        w = '0;
        w[34] = md;    w[33] = acc;   w[32] = pcen;  w[31] = pwen;
        w[30:20] = paddr;
        w[19] = xcen;  w[18] = xwen;
        w[17:7] = xaddr;
        w[6] = ofrd;   w[3] = l0rd;   w[2] = l0wr;   w[1] = exe;   w[0] = ld;
        return w;
    endfunction

    function automatic logic [34:0] nopw(input logic md);
        return mkw(md, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle on instance A with bookkeeping and the bus field rules.
    task automatic tick_a();
        @(posedge clk);
        #1;
        if (busy_a) busy_cnt++;
        if (done_a) done_cnt++;
        if (inst_a[1]) exe_cnt++;
        tests++;
        if ((inst_a[19] && !inst_a[18]) || (!inst_a[31] && !inst_a[6])) begin
            fails++;
            $display("FAIL field_rule: inst=%h, need xmem WEN=1 whenever CEN=1 and psum WEN=0 only with ofifo_rd", inst_a);
        end
    endtask

    task automatic push(input logic b, input logic d, input logic [34:0] w);
        obs_t o;
        o.busy = b;
        o.done = d;
        o.inst = w;
        sb.push_back(o);
    endtask

    initial begin
        int guard;
        int done_lat;
        logic ord_ran;
        obs_t e;

        ord_tbl[0] = '{1'b1, 1'b0, mkw(1'b0, 1'b0, 1'b0, 1'b0, 11'd72, 1'b1, 1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
        ord_tbl[1] = '{1'b0, 1'b0, nopw(1'b0)};
        ord_tbl[2] = '{1'b1, 1'b0, mkw(1'b0, 1'b0, 1'b0, 1'b0, 11'd73, 1'b1, 1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
        ord_tbl[3] = '{1'b0, 1'b0, nopw(1'b0)};
        ord_tbl[4] = '{1'b1, 1'b0, mkw(1'b0, 1'b0, 1'b0, 1'b0, 11'd74, 1'b1, 1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
        ord_tbl[5] = '{1'b1, 1'b0, mkw(1'b0, 1'b0, 1'b0, 1'b0, 11'd75, 1'b1, 1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};

        acc_tbl[0] = '{1'b1, 1'b0, mkw(1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        acc_tbl[1] = '{1'b1, 1'b0, mkw(1'b0, 1'b1, 1'b0, 1'b1, 11'd2, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        acc_tbl[2] = '{1'b1, 1'b0, mkw(1'b0, 1'b1, 1'b0, 1'b1, 11'd4, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        acc_tbl[3] = '{1'b1, 1'b0, mkw(1'b0, 1'b1, 1'b0, 1'b1, 11'd1, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        acc_tbl[4] = '{1'b1, 1'b0, mkw(1'b0, 1'b1, 1'b0, 1'b1, 11'd3, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        acc_tbl[5] = '{1'b1, 1'b0, mkw(1'b0, 1'b1, 1'b0, 1'b1, 11'd5, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        acc_tbl[6] = '{1'b1, 1'b0, mkw(1'b0, 1'b1, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        acc_tbl[7] = '{1'b1, 1'b1, nopw(1'b0)};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        mode_a = 1'b0; mode_b = 1'b0; mode_c = 1'b0;
        valid_a = 1'b1; valid_b = 1'b1; valid_c = 1'b1;
        busy_cnt = 0; done_cnt = 0; exe_cnt = 0;

        // Reset state on all instances.
        tick();
        tick();
        chk("reset_a", 64'({busy_a, done_a, inst_a}), 64'({1'b0, 1'b0, NOP}));
        chk("reset_b", 64'({busy_b, done_b, inst_b}), 64'({1'b0, 1'b0, NOP}));
        chk("reset_c", 64'({busy_c, done_c, inst_c}), 64'({1'b0, 1'b0, NOP}));
`ifdef CORE_INST_SEQ_PERF_EN
        chk("reset_perf_a", 64'({cyc_a, stall_a}), 64'd0);
`endif
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick();

        // Short tile on B: full expected stream goes to the scoreboard at start.
        start_b = 1'b1;
        mode_b  = 1'b1;
        for (int i = 0; i <= 8; i++)
            push(1'b1, 1'b0, mkw(1'b1, 1'b0, 1'b1, 1'b1, 11'd0, (i >= 8), 1'b1,
                                 (i < 8) ? 11'(1024 + i) : 11'd0, 1'b0, 1'b0, (i > 0), 1'b0, 1'b0));
        for (int i = 0; i < 8; i++)
            push(1'b1, 1'b0, mkw(1'b1, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 8; i++)
            push(1'b1, 1'b0, nopw(1'b1));
        for (int i = 0; i <= 4; i++)
            push(1'b1, 1'b0, mkw(1'b1, 1'b0, 1'b1, 1'b1, 11'd0, (i >= 4), 1'b1,
                                 (i < 4) ? 11'(i) : 11'd0, 1'b0, 1'b0, (i > 0), 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            push(1'b1, 1'b0, mkw(1'b1, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 4; i++)
            push(1'b1, 1'b0, mkw(1'b1, 1'b0, 1'b0, 1'b0, 11'(i), 1'b1, 1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i <= 4; i++)
            push(1'b1, 1'b0, mkw(1'b1, (i > 0), (i >= 4), 1'b1, (i < 4) ? 11'(i) : 11'd0,
                                 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        push(1'b0, 1'b1, nopw(1'b1));
        tick();
        start_b = 1'b0;
        mode_b  = 1'b0;
        chk("b_after_start", 64'({busy_b, done_b, inst_b}), 64'({1'b1, 1'b0, NOP}));
        done_lat = 0;
        for (int i = 0; i < 44; i++) begin
            tick();
            e = sb.pop_front();
            chk($sformatf("b_word%0d", i), 64'({busy_b, done_b, inst_b}), 64'(e));
            if (done_b && done_lat == 0) done_lat = i + 1;
        end
        chk("b_done_latency", 64'(done_lat), 64'd44);
        tick();
        chk("b_idle_after", 64'({busy_b, done_b, inst_b}), 64'({1'b0, 1'b0, NOP}));

        // ACC readout order on C.
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        guard = 0;
        while (!(inst_c[32] == 1'b0 && inst_c[31] == 1'b1) && guard < 300) begin
            tick();
            guard++;
        end
        chk("c_acc_reached", 64'(guard < 300), 64'd1);
        for (int r = 0; r < 8; r++) begin
            if (r > 0) tick();
            chk($sformatf("c_acc_row%0d", r), 64'({done_c, inst_c}),
                64'({acc_tbl[r].exp_done, acc_tbl[r].exp_inst}));
        end

        // Full default tile on A: ORD stalls at kij=2, extra start while busy.
        busy_cnt = 0; done_cnt = 0; exe_cnt = 0;
        ord_ran = 1'b0;
        start_a = 1'b1;
        tick_a();
        start_a = 1'b0;
        guard = 0;
        while (done_cnt == 0 && guard < 4000) begin
            if (guard == 50) begin
                start_a = 1'b1;
                mode_a  = 1'b1;
            end
            tick_a();
            guard++;
            start_a = 1'b0;
            mode_a  = 1'b0;
            if (exe_cnt == 108 && !ord_ran) begin
                ord_ran = 1'b1;
                for (int r = 0; r < 6; r++) begin
                    valid_a = ord_tbl[r].valid_in;
                    tick_a();
                    guard++;
                    chk($sformatf("a_ord_row%0d", r), 64'({done_a, inst_a}),
                        64'({ord_tbl[r].exp_done, ord_tbl[r].exp_inst}));
                end
                valid_a = 1'b1;
            end
        end
        chk("a_ord_reached", 64'(ord_ran), 64'd1);
        for (int i = 0; i < 20; i++) tick_a();
        chk("a_done_count", 64'(done_cnt), 64'd1);
        chk("a_busy_cycles", 64'(busy_cnt), 64'd1534);
        chk("a_idle_after", 64'({busy_a, done_a, inst_a}), 64'({1'b0, 1'b0, NOP}));
`ifdef CORE_INST_SEQ_PERF_EN
        chk("a_cyc_cnt", 64'(cyc_a), 64'd1534);
        chk("a_stall_cnt", 64'(stall_a), 64'd2);
`endif

        // Restart A and abort with reset during EXE of kij=3.
        busy_cnt = 0; done_cnt = 0; exe_cnt = 0;
        start_a = 1'b1;
        tick_a();
        start_a = 1'b0;
`ifdef CORE_INST_SEQ_PERF_EN
        chk("a_perf_clear_on_start", 64'({cyc_a, stall_a}), 64'd0);
`endif
        guard = 0;
        while (exe_cnt < 120 && guard < 2000) begin
            tick_a();
            guard++;
        end
        chk("a_exe_kij3_reached", 64'(exe_cnt), 64'd120);
        rst_a = 1'b1;
        #1;
        chk("a_reset_async", 64'({busy_a, done_a, inst_a}), 64'({1'b0, 1'b0, NOP}));
        tick_a();
        chk("a_reset_next", 64'({busy_a, done_a, inst_a}), 64'({1'b0, 1'b0, NOP}));
        rst_a = 1'b0;
        done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 60; i++) tick_a();
        chk("a_no_done_after_abort", 64'(done_cnt), 64'd0);
        chk("a_no_busy_after_abort", 64'(busy_cnt), 64'd0);
        chk("a_nop_after_abort", 64'(inst_a), 64'(NOP));
`ifdef CORE_INST_SEQ_PERF_EN
        chk("a_perf_after_reset", 64'({cyc_a, stall_a}), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
